// File: rtl/nand_seq_lu.sv
// nand_seq_lu: sequential multi-function bitwise logic unit.
//
// Captures operands r2/r3 and op on an accepted start, then produces the
// result K bits per cycle, least-significant slice first. r1 holds its
// value until the next accepted start.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous active-high reset, aborts any operation
//   start  - request, sampled only while idle
//   op     - operation select (NAND/AND/OR/NOR/XOR/XNOR/NOT r2/pass r2)
//   r2, r3 - operands A and B
//   r1     - result register
//   busy   - high while slices are being computed
//   done   - one-cycle pulse, r1 complete while high
//   zero   - (LU_FLAGS_EN only) r1 == 0, updated on completion
//   parity - (LU_FLAGS_EN only) XOR-reduce of r1, updated on completion
//
// Optional feature macro: LU_FLAGS_EN adds the zero/parity flag outputs.
module nand_seq_lu #(
  parameter int N = 8,
  parameter int K = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] r2,
  input  logic [N-1:0] r3,
  output logic [N-1:0] r1,
  output logic         busy,
  output logic         done
`ifdef LU_FLAGS_EN
  ,
  output logic         zero,
  output logic         parity
`endif
);

  localparam int BEATS = N / K;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [K-1:0]     slice_res;
  logic [N-1:0]     r1_nxt;

  function automatic logic [K-1:0] lu_op(input logic [2:0]   o,
                                         input logic [K-1:0] a,
                                         input logic [K-1:0] b);
    logic [K-1:0] y;
    case (o)
      3'b000:  y = ~(a & b);
      3'b001:  y = a & b;
      3'b010:  y = a | b;
      3'b011:  y = ~(a | b);
      3'b100:  y = a ^ b;
      3'b101:  y = ~(a ^ b);
      3'b110:  y = ~a;
      default: y = a;
    endcase
    return y;
  endfunction

  // r1 with the current beat's slice merged in; the flags are taken from
  // this so they include the last slice on the edge entering DONE.
  always_comb begin
    slice_res = lu_op(op_q, a_q[int'(cnt)*K +: K], b_q[int'(cnt)*K +: K]);
    r1_nxt = r1;
    r1_nxt[int'(cnt)*K +: K] = slice_res;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      r1     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef LU_FLAGS_EN
      zero   <= 1'b0;
      parity <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= op;
            a_q   <= r2;
            b_q   <= r3;
            r1    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          r1 <= r1_nxt;
          if (cnt == LAST_BEAT) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
`ifdef LU_FLAGS_EN
            zero   <= (r1_nxt == '0);
            parity <= ^r1_nxt;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand_seq_lu.sv
module tb_nand_seq_lu;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] r2;
  logic [7:0] r3;
  logic [7:0] r1;
  logic       busy;
  logic       done;
  logic       start1;
  logic [2:0] op1;
  logic [7:0] r2_1;
  logic [7:0] r3_1;
  logic [7:0] r1_1;
  logic       busy1;
  logic       done1;
`ifdef LU_FLAGS_EN
  logic       zero;
  logic       parity;
  logic       zero1;
  logic       parity1;
`endif

  int passed;
  int total;

  nand_seq_lu #(.N(8), .K(2)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .r2(r2), .r3(r3),
    .r1(r1), .busy(busy), .done(done)
`ifdef LU_FLAGS_EN
    , .zero(zero), .parity(parity)
`endif
  );

  nand_seq_lu #(.N(8), .K(8)) u_one (
    .clk(clk), .reset(reset), .start(start1), .op(op1), .r2(r2_1), .r3(r3_1),
    .r1(r1_1), .busy(busy1), .done(done1)
`ifdef LU_FLAGS_EN
    , .zero(zero1), .parity(parity1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    op = o; r2 = a; r3 = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    total++; if (r1 !== 8'h00) $display("FAIL reset_r1 got %h want 00", r1); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (r1_1 !== 8'h00 || busy1 !== 1'b0 || done1 !== 1'b0)
      $display("FAIL reset_one got r1=%h busy=%b done=%b want 00/0/0", r1_1, busy1, done1);
    else passed++;
`ifdef LU_FLAGS_EN
    total++; if (zero !== 1'b0 || parity !== 1'b0)
      $display("FAIL reset_flags got zero=%b parity=%b want 0/0", zero, parity);
    else passed++;
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_nand;
    logic [7:0] exp_partial [4];
    exp_partial[0] = 8'h00; exp_partial[1] = 8'h03;
    exp_partial[2] = 8'h0F; exp_partial[3] = 8'h3F;
    accept(3'b000, 8'hF0, 8'hCC);
    for (int i = 0; i < 4; i++) begin
      total++; if (busy !== 1'b1 || done !== 1'b0)
        $display("FAIL nand_busy beat %0d got busy=%b done=%b want 1/0", i, busy, done);
      else passed++;
      total++; if (r1 !== exp_partial[i])
        $display("FAIL nand_partial beat %0d got %h want %h", i, r1, exp_partial[i]);
      else passed++;
      tick();
    end
    total++; if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL nand_done got done=%b busy=%b want 1/0", done, busy);
    else passed++;
    total++; if (r1 !== 8'h3F) $display("FAIL nand_result got %h want 3f", r1); else passed++;
    tick();
    total++; if (done !== 1'b0) $display("FAIL nand_done_width got %b want 0", done); else passed++;
    total++; if (r1 !== 8'h3F) $display("FAIL nand_hold got %h want 3f", r1); else passed++;
    tick();
  endtask

  task automatic test_back_to_back;
    op = 3'b100; r2 = 8'hAA; r3 = 8'h0F; start = 1'b1;
    tick();
    op = 3'b111; r2 = 8'h5C; r3 = 8'h00;
    for (int i = 0; i < 4; i++) tick();
    total++; if (done !== 1'b1 || r1 !== 8'hA5)
      $display("FAIL b2b_xor got done=%b r1=%h want 1/a5", done, r1);
    else passed++;
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL b2b_gap got busy=%b done=%b want 0/0", busy, done);
    else passed++;
    tick();
    total++; if (busy !== 1'b1 || r1 !== 8'h00)
      $display("FAIL b2b_accept got busy=%b r1=%h want 1/00", busy, r1);
    else passed++;
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total++; if (done !== 1'b1 || r1 !== 8'h5C)
      $display("FAIL b2b_pass got done=%b r1=%h want 1/5c", done, r1);
    else passed++;
    tick(); tick();
  endtask

  task automatic test_mid_run;
    int dones;
    logic [7:0] r1_at_done;
    dones = 0;
    r1_at_done = 8'h00;
    accept(3'b001, 8'h3C, 8'h0F);
    tick();
    start = 1'b1; op = 3'b000; r2 = 8'hFF; r3 = 8'hFF;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) begin
        dones++;
        r1_at_done = r1;
      end
      tick();
    end
    total++; if (dones !== 1) $display("FAIL mid_done_count got %0d want 1", dones); else passed++;
    total++; if (r1_at_done !== 8'h0C) $display("FAIL mid_result got %h want 0c", r1_at_done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_idle_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid_run;
    int dones;
    dones = 0;
    accept(3'b000, 8'hF0, 8'hCC);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (r1 !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rstmid_state got r1=%h busy=%b done=%b want 00/0/0", r1, busy, done);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    total++; if (dones !== 0) $display("FAIL rstmid_no_done got %0d want 0", dones); else passed++;
    accept(3'b000, 8'hF0, 8'hCC);
    for (int i = 0; i < 4; i++) tick();
    total++; if (done !== 1'b1 || r1 !== 8'h3F)
      $display("FAIL rstmid_restart got done=%b r1=%h want 1/3f", done, r1);
    else passed++;
    tick(); tick();
  endtask

  task automatic test_single_beat;
    op1 = 3'b011; r2_1 = 8'h0F; r3_1 = 8'h30; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    total++; if (busy1 !== 1'b1 || done1 !== 1'b0)
      $display("FAIL single_run got busy=%b done=%b want 1/0", busy1, done1);
    else passed++;
    tick();
    total++; if (done1 !== 1'b1 || busy1 !== 1'b0 || r1_1 !== 8'hC0)
      $display("FAIL single_done got done=%b busy=%b r1=%h want 1/0/c0", done1, busy1, r1_1);
    else passed++;
    tick();
    total++; if (done1 !== 1'b0 || r1_1 !== 8'hC0)
      $display("FAIL single_after got done=%b r1=%h want 0/c0", done1, r1_1);
    else passed++;
  endtask

`ifdef LU_FLAGS_EN
  task automatic test_flags;
    accept(3'b001, 8'hF0, 8'h0F);
    for (int i = 0; i < 4; i++) tick();
    total++; if (r1 !== 8'h00 || zero !== 1'b1 || parity !== 1'b0)
      $display("FAIL flags_and got r1=%h zero=%b parity=%b want 00/1/0", r1, zero, parity);
    else passed++;
    tick(); tick();
    accept(3'b010, 8'h01, 8'h02);
    total++; if (zero !== 1'b1) $display("FAIL flags_hold got zero=%b want 1", zero); else passed++;
    for (int i = 0; i < 4; i++) tick();
    total++; if (r1 !== 8'h03 || zero !== 1'b0 || parity !== 1'b0)
      $display("FAIL flags_or got r1=%h zero=%b parity=%b want 03/0/0", r1, zero, parity);
    else passed++;
    tick(); tick();
    accept(3'b110, 8'hFE, 8'h55);
    for (int i = 0; i < 4; i++) tick();
    total++; if (r1 !== 8'h01 || zero !== 1'b0 || parity !== 1'b1)
      $display("FAIL flags_not got r1=%h zero=%b parity=%b want 01/0/1", r1, zero, parity);
    else passed++;
    tick(); tick();
  endtask
`endif

  initial begin
    passed = 0; total = 0;
    reset = 1'b1; start = 1'b0; op = 3'b000; r2 = 8'h00; r3 = 8'h00;
    start1 = 1'b0; op1 = 3'b000; r2_1 = 8'h00; r3_1 = 8'h00;
    test_reset();
    test_nand();
    test_back_to_back();
    test_mid_run();
    test_reset_mid_run();
    test_single_beat();
`ifdef LU_FLAGS_EN
    test_flags();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
